// File: rtl/button_event_queue_pkg.sv
// Shared constants and event encoding for the controller button event path.
// Button indices follow the serial reader's bit order.
package button_event_queue_pkg;

  localparam int EVT_W         = 4;
  localparam int EVT_PRESS_BIT = 3;
  localparam int BTN_IDX_W     = 3;
  localparam int NUM_BUTTONS   = 8;

  localparam logic [BTN_IDX_W-1:0] BTN_B      = 3'd0;
  localparam logic [BTN_IDX_W-1:0] BTN_Y      = 3'd1;
  localparam logic [BTN_IDX_W-1:0] BTN_SELECT = 3'd2;
  localparam logic [BTN_IDX_W-1:0] BTN_START  = 3'd3;
  localparam logic [BTN_IDX_W-1:0] BTN_UP     = 3'd4;
  localparam logic [BTN_IDX_W-1:0] BTN_DOWN   = 3'd5;
  localparam logic [BTN_IDX_W-1:0] BTN_LEFT   = 3'd6;
  localparam logic [BTN_IDX_W-1:0] BTN_RIGHT  = 3'd7;

  typedef logic [EVT_W-1:0] evt_t;

  function automatic evt_t make_evt(input logic is_press, input logic [BTN_IDX_W-1:0] idx);
    evt_t e;
    e                 = '0;
    e[BTN_IDX_W-1:0]  = idx;
    e[EVT_PRESS_BIT]  = is_press;
    return e;
  endfunction

endpackage

// File: rtl/button_event_queue_if.sv
// Valid/ready event stream from the button queue to the command sequencer.
interface button_event_queue_if;
  import button_event_queue_pkg::*;

  logic evt_valid;
  evt_t evt_data;
  logic evt_ready;

  modport master (output evt_valid, output evt_data, input evt_ready);
  modport slave  (input evt_valid, input evt_data, output evt_ready);

endinterface

// File: rtl/button_event_queue_event_fifo.sv
// Show-ahead FIFO with occupancy count; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module event_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     push_ready,
  output logic                     pop_valid,
  output logic [WIDTH-1:0]         pop_data,
  input  logic                     pop_ready,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Flop storage keeps the head readable in the same cycle it is written.
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push, do_pop;

  assign pop_valid  = (count_reg != '0);
  assign pop_data   = mem_reg[rd_ptr_reg];
  assign do_pop     = pop_valid && pop_ready;
  assign push_ready = (count_reg != FULL_CNT) || do_pop;
  assign do_push    = push && push_ready;
  assign count      = count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg          <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/button_event_queue.sv
// Per-button frame debounce, pending press/release masks with priority drain,
// feeding an event FIFO toward the command sequencer.
module button_event_queue
  import button_event_queue_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int FIFO_DEPTH      = 8,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_BUTTONS-1:0]        buttons,
  input  logic                          frame_tick,
  button_event_queue_if.master          evt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);
  localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_FRAMES - 1);

  logic [NUM_BUTTONS-1:0] raw, edge_det, press_edge, release_edge, busy, collide;
  logic [NUM_BUTTONS-1:0] clr_mask, clr_press, clr_release;
  logic [NUM_BUTTONS-1:0] pend_press_reg, pend_press_next;
  logic [NUM_BUTTONS-1:0] pend_release_reg, pend_release_next;
  logic                   overflow_reg, overflow_next;
  logic                   sel_valid, sel_press, drain, fifo_push_ready;
  logic [BTN_IDX_W-1:0]   sel_idx;
  evt_t                   push_evt;

  assign raw = ACTIVE_LOW ? ~buttons : buttons;

  generate
    for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
      logic [3:0] cnt_reg;
      logic       deb_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_reg <= '0;
          deb_reg <= 1'b0;
        end else if (frame_tick) begin
          if (raw[gi] == deb_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_MAX) begin
            deb_reg <= raw[gi];
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign edge_det[gi] = frame_tick && (raw[gi] != deb_reg) && (cnt_reg == CNT_MAX);
    end
  endgenerate

  assign press_edge   = edge_det & raw;
  assign release_edge = edge_det & ~raw;
  // A button with either bit pending cannot take another edge; the new one is lost.
  assign busy         = pend_press_reg | pend_release_reg;
  assign collide      = edge_det & busy;

  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (busy[i]) begin
        sel_valid = 1'b1;
        sel_idx   = BTN_IDX_W'(i);
      end
    end
  end

  assign sel_press   = pend_press_reg[sel_idx];
  assign drain       = sel_valid && fifo_push_ready;
  assign clr_mask    = drain ? (NUM_BUTTONS'(1) << sel_idx) : '0;
  assign clr_press   = sel_press ? clr_mask : '0;
  assign clr_release = sel_press ? '0 : clr_mask;
  assign push_evt    = make_evt(sel_press, sel_idx);

  assign pend_press_next   = (pend_press_reg & ~clr_press) | (press_edge & ~busy);
  assign pend_release_next = (pend_release_reg & ~clr_release) | (release_edge & ~busy);
  assign overflow_next     = overflow_reg | (|collide);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_press_reg   <= '0;
      pend_release_reg <= '0;
      overflow_reg     <= 1'b0;
    end else begin
      pend_press_reg   <= pend_press_next;
      pend_release_reg <= pend_release_next;
      overflow_reg     <= overflow_next;
    end
  end

  assign overflow = overflow_reg;

  event_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (drain),
    .push_data  (push_evt),
    .push_ready (fifo_push_ready),
    .pop_valid  (evt.evt_valid),
    .pop_data   (evt.evt_data),
    .pop_ready  (evt.evt_ready),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_button_event_queue.sv
// Self-checking bench: debounce vector table plus hand-written FIFO/reset sequences,
// with an expected-event scoreboard compared on every accepted pop.
module tb_button_event_queue;
  import button_event_queue_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] buttons = 8'hFF;
  logic       frame_tick = 1'b0;
  logic [3:0] fifo_count;
  logic       overflow;

  button_event_queue_if bus ();

  always #5 clk = ~clk;

  button_event_queue #(
    .DEBOUNCE_FRAMES (3),
    .FIFO_DEPTH      (8),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .buttons    (buttons),
    .frame_tick (frame_tick),
    .evt        (bus),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_q[$];

  typedef struct packed {
    logic [7:0]  btns;
    logic [3:0]  frames;
    logic [3:0]  nexp;
    logic [31:0] evts;   // expected events, nibble k = k-th event
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Score any pop that the upcoming edge will perform, then advance one cycle.
  task automatic step();
    if (bus.evt_valid && bus.evt_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event actual=%0h expected=none", bus.evt_data);
      end else begin
        check("event", int'(bus.evt_data), int'(exp_q.pop_front()));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [7:0] b);
    buttons    = b;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic frames(input logic [7:0] b, input int n);
    repeat (n) frame(b);
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.evt_valid) && n < max_cyc) begin
      step();
      n++;
    end
    check("drain_done", int'(exp_q.size() == 0 && !bus.evt_valid), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{8'hFE, 4'd2, 4'd0, 32'h0};       // 2-frame glitch on B
    vecs[1] = '{8'hFF, 4'd3, 4'd0, 32'h0};
    vecs[2] = '{8'hFD, 4'd3, 4'd1, 32'h9};       // press Y
    vecs[3] = '{8'hFF, 4'd3, 4'd1, 32'h1};       // release Y
    vecs[4] = '{8'h7F, 4'd3, 4'd1, 32'hF};       // press RIGHT
    vecs[5] = '{8'hFF, 4'd1, 4'd0, 32'h0};       // 1-frame release glitch
    vecs[6] = '{8'h7F, 4'd1, 4'd0, 32'h0};
    vecs[7] = '{8'hFF, 4'd3, 4'd1, 32'h7};
    vecs[8] = '{8'h5A, 4'd3, 4'd4, 32'h0000FDA8}; // press 0,2,5,7 in index order
    vecs[9] = '{8'hFF, 4'd3, 4'd4, 32'h00007520}; // release 0,2,5,7

    bus.evt_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", int'(bus.evt_valid), 0);
    check("rst_data", int'(bus.evt_data), 0);
    check("rst_count", int'(fifo_count), 0);
    check("rst_overflow", int'(overflow), 0);
    reset_n = 1'b1;
    step();

    // Latency: third frame at T, head valid at T+2.
    frames(8'hFE, 2);
    buttons    = 8'hFE;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("lat_t1_valid", int'(bus.evt_valid), 0);
    step();
    check("lat_t2_valid", int'(bus.evt_valid), 1);
    check("lat_t2_data", int'(bus.evt_data), 8);
    check("lat_t2_count", int'(fifo_count), 1);
    exp_q.push_back(4'h8);
    bus.evt_ready = 1'b1;
    wait_drain(20);
    exp_q.push_back(4'h0);
    frames(8'hFF, 3);
    wait_drain(20);

    for (int v = 0; v < 10; v++) begin
      for (int k = 0; k < int'(vecs[v].nexp); k++) exp_q.push_back(vecs[v].evts[4*k +: 4]);
      frames(vecs[v].btns, int'(vecs[v].frames));
      repeat (3) step();
      wait_drain(30);
      check($sformatf("vec%0d_count", v), int'(fifo_count), 0);
      check($sformatf("vec%0d_overflow", v), int'(overflow), 0);
    end

    // Fill the FIFO: presses 0,1,4,6,7 then releases 0,1,4.
    bus.evt_ready = 1'b0;
    exp_q.push_back(4'h8); exp_q.push_back(4'h9); exp_q.push_back(4'hC);
    exp_q.push_back(4'hE); exp_q.push_back(4'hF);
    frames(8'h2C, 3);
    exp_q.push_back(4'h0); exp_q.push_back(4'h1); exp_q.push_back(4'h4);
    frames(8'h3F, 3);
    repeat (4) step();
    check("full_count", int'(fifo_count), 8);

    // Presses on 3 and 5 wait while full.
    exp_q.push_back(4'hB);
    frames(8'h17, 3);
    repeat (4) step();
    check("held_count", int'(fifo_count), 8);
    check("held_overflow", int'(overflow), 0);
    bus.evt_ready = 1'b1;
    step();
    bus.evt_ready = 1'b0;
    check("pop_push_count", int'(fifo_count), 8);

    // Press on 2 pending, then its release collides and is dropped.
    exp_q.push_back(4'hA); exp_q.push_back(4'hD);
    frames(8'h13, 3);
    frames(8'h17, 3);
    repeat (2) step();
    check("collide_overflow", int'(overflow), 1);
    check("collide_count", int'(fifo_count), 8);
    bus.evt_ready = 1'b1;
    wait_drain(40);
    check("post_collide_count", int'(fifo_count), 0);
    check("overflow_sticky", int'(overflow), 1);

    // Release everything still held (3,5,6,7).
    exp_q.push_back(4'h3); exp_q.push_back(4'h5);
    exp_q.push_back(4'h6); exp_q.push_back(4'h7);
    frames(8'hFF, 3);
    wait_drain(30);

    // All eight pressed on one frame: one push per cycle, peak 8.
    bus.evt_ready = 1'b0;
    for (int k = 0; k < 8; k++) exp_q.push_back(4'(8 + k));
    frames(8'h00, 2);
    buttons    = 8'h00;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("burst_c0", int'(fifo_count), 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("burst_c%0d", k), int'(fifo_count), k);
    end

    // Reset mid-drain with 5 queued.
    bus.evt_ready = 1'b1;
    repeat (3) step();
    bus.evt_ready = 1'b0;
    check("pre_reset_count", int'(fifo_count), 5);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(bus.evt_valid), 0);
    check("mid_rst_count", int'(fifo_count), 0);
    check("mid_rst_overflow", int'(overflow), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) exp_q.push_back(4'(8 + k));
    bus.evt_ready = 1'b1;
    frames(8'h00, 2);
    check("post_rst_no_early", int'(bus.evt_valid), 0);
    frames(8'h00, 1);
    wait_drain(30);
    check("final_count", int'(fifo_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_event_queue.md
Name: button_event_queue

Overview:
- Sits directly downstream of the serial controller reader. Consumes its 8-bit parallel button word once per controller frame.
- Debounces each button across frames and turns debounced press/release transitions into 4-bit events.
- Queues events in a small FIFO with a valid/ready interface toward the cube-move command sequencer.

Parameters:
- DEBOUNCE_FRAMES, 3: consecutive identical frames needed before a button's debounced state changes (legal 1..15).
- FIFO_DEPTH, 8: event FIFO entries (power of two, 2..16).
- ACTIVE_LOW, 1: 1 = raw button bit 0 means pressed; the input is inverted before debouncing.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- buttons  input  8  raw button word from the upstream reader, stable whenever frame_tick is high.
- frame_tick  input  1  one-cycle pulse: buttons holds a new frame.
- evt_valid  output  1  FIFO head is valid.
- evt_data  output  4  [3] = 1 press / 0 release, [2:0] = button index.
- evt_ready  input  1  consumer accepts the head this cycle.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  output  1  sticky: an event was lost. Cleared only by reset.

Behaviour:
- Reset (async assert, sync release): debounced state = all released, debounce counters = 0, pending masks = 0, FIFO empty. evt_valid = 0, evt_data = 0, fifo_count = 0, overflow = 0.
- A button held through reset yields a press event once debounced.
- Ownership: raw = ACTIVE_LOW ? ~buttons : buttons. Each button has a counter, updated only on frame_tick.
  - raw == debounced: counter <= 0.
  - raw != debounced and counter == DEBOUNCE_FRAMES-1: debounced flips, counter <= 0, edge generated.
  - Otherwise: counter + 1.
  - A glitch shorter than DEBOUNCE_FRAMES frames produces no event. With DEBOUNCE_FRAMES = 1 the flip occurs on the first differing frame.
- Edges set bits in pend_press[7:0] or pend_release[7:0] in the frame_tick cycle.
- Collision: if an edge targets a button whose press or release pending bit is already set, the new edge is dropped and overflow is set. The existing pending bit is kept.
- Drain: at most one event per cycle.
  - Selected source is the lowest button index with any pending bit. For a given index, press is drained before release.
  - The event is written to the FIFO and its pending bit cleared in the same cycle.
  - If the FIFO is full and no pop occurs this cycle, nothing drains and pending bits wait. No drop occurs here.
- FIFO: show-ahead. evt_data is valid whenever evt_valid = 1 and holds stable until the pop.
  - Pop occurs when evt_valid && evt_ready.
  - Push while full is allowed only if a pop happens in the same cycle.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: a lone edge on frame_tick at cycle T with the FIFO empty drives evt_valid = 1 at cycle T+2 (pending at T+1, written at T+1, visible at T+2).
- frame_tick during the drain is legal. New edges OR into the masks in the same cycle as a drain clear, and a set and a clear on different bits do not interfere.
- evt_ready while evt_valid = 0 is ignored.
- No combinational path from evt_ready to evt_valid or evt_data.

Decomposition:
- Shared package holds:
  - EVT_W = 4, EVT_PRESS_BIT = 3, BTN_IDX_W = 3, NUM_BUTTONS = 8.
  - Button index constants, ordered to match the reader's bit order, e.g. BTN_B = 0 .. BTN_RIGHT = 7.
- One sub-module: event_fifo (parameterised width/depth, show-ahead, count output), reusable by the command sequencer.
- Debounce, pending masks and priority select stay in the top module.

Test Plan:
- ACTIVE_LOW = 1, buttons = 8'hFE held for 3 ticks -> after the third tick, evt_data = 4'b1000 (press, index 0) at T+2. Then buttons = 8'hFF for 3 ticks -> 4'b0000.
- buttons = 8'hFE for 2 ticks then 8'hFF -> no event, fifo_count stays 0.
- Single frame transition 8'hFF -> 8'h00 (after debouncing) -> 8 press events, indices 0..7 in order, one per cycle, fifo_count peaks at 8 with evt_ready = 0.
- FIFO full (8 entries, evt_ready = 0), 2 more press edges on indices 3 and 5 -> both held pending, overflow = 0. Release evt_ready for 1 cycle -> index 3 pushed same cycle as pop, fifo_count stays 8.
- Button 2 press pending (FIFO full) then a debounced release of button 2 -> overflow = 1, only the press is delivered later.
- Assert reset_n = 0 mid-drain with 5 queued -> evt_valid = 0, fifo_count = 0, overflow = 0 immediately. Release with buttons held pressed -> presses re-emitted after 3 ticks.
